hdmi_timing_gen: RTL and testbench

- Video timing generator in the HDMI pixel clock domain of display_ibex_top.
- Produces raster coordinates and pixel requests for the framebuffer read path.
- Takes back RGB with a fixed 1-cycle latency and drives the registered, mutually aligned hdmi_tx_de/hs/vs/r/g/b outputs.
- Start/stop is frame-gated so the sink never sees a truncated frame.

---
 rtl/hdmi_timing_gen.sv | 163 ++++++++++++++++
 tb/tb_hdmi_timing_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_gen.sv
// Video raster timing generator: counts pixels and lines, requests framebuffer pixels,
// and drives registered, mutually aligned HDMI DE/HS/VS/RGB with a 2-cycle pipeline.
module hdmi_timing_gen #(
  parameter int   HActive  = 640,
  parameter int   HFront   = 16,
  parameter int   HSync    = 96,
  parameter int   HBack    = 48,
  parameter int   VActive  = 480,
  parameter int   VFront   = 10,
  parameter int   VSync    = 2,
  parameter int   VBack    = 33,
  parameter logic HSyncPol = 1'b0,
  parameter logic VSyncPol = 1'b0
) (
  input  logic                       clk_hdmi_i,
  input  logic                       rst_hdmi_ni,
  input  logic                       enable_i,
  output logic                       pix_req_o,
  output logic [$clog2(HActive)-1:0] pix_x_o,
  output logic [$clog2(VActive)-1:0] pix_y_o,
  input  logic [7:0]                 pix_r_i,
  input  logic [7:0]                 pix_g_i,
  input  logic [7:0]                 pix_b_i,
  output logic                       frame_start_o,
  output logic                       running_o,
  output logic                       hdmi_tx_de_o,
  output logic                       hdmi_tx_hs_o,
  output logic                       hdmi_tx_vs_o,
  output logic [7:0]                 hdmi_tx_r_o,
  output logic [7:0]                 hdmi_tx_g_o,
  output logic [7:0]                 hdmi_tx_b_o
);

  localparam int HTotal = HActive + HFront + HSync + HBack;
  localparam int VTotal = VActive + VFront + VSync + VBack;
  localparam int HW     = $clog2(HTotal);
  localparam int VW     = $clog2(VTotal);
  localparam int XW     = $clog2(HActive);
  localparam int YW     = $clog2(VActive);

  // One extra bit so region bounds equal to the total still fit.
  localparam logic [HW:0]   HActEnd = (HW+1)'(HActive);
  localparam logic [HW:0]   HsStart = (HW+1)'(HActive + HFront);
  localparam logic [HW:0]   HsEnd   = (HW+1)'(HActive + HFront + HSync);
  localparam logic [VW:0]   VActEnd = (VW+1)'(VActive);
  localparam logic [VW:0]   VsStart = (VW+1)'(VActive + VFront);
  localparam logic [VW:0]   VsEnd   = (VW+1)'(VActive + VFront + VSync);
  localparam logic [HW-1:0] HLast   = HW'(HTotal - 1);
  localparam logic [VW-1:0] VLast   = VW'(VTotal - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic            running_q;

  logic            req_q, fs_q, hs_act_q, vs_act_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;

  logic            de_q, hs_q, vs_q;
  logic [7:0]      r_q, g_q, b_q;

  logic            h_last, v_last, counting;
  logic            active_s0, hs_act_s0, vs_act_s0, fs_s0;
  logic [HW:0]     h_ext;
  logic [VW:0]     v_ext;

  assign h_last   = (h_cnt_q == HLast);
  assign v_last   = (v_cnt_q == VLast);
  assign counting = (state_q != IDLE);
  assign h_ext    = {1'b0, h_cnt_q};
  assign v_ext    = {1'b0, v_cnt_q};

  // Stage 0: region decode, forced inactive while idle so the outputs blank.
  assign active_s0 = counting && (h_ext < HActEnd) && (v_ext < VActEnd);
  assign hs_act_s0 = counting && (h_ext >= HsStart) && (h_ext < HsEnd);
  assign vs_act_s0 = counting && (v_ext >= VsStart) && (v_ext < VsEnd);
  assign fs_s0     = counting && (h_cnt_q == '0) && (v_cnt_q == '0);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    unique case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (enable_i) state_d = RUN;
      end
      RUN, DRAIN: begin
        h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
        if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
        if (state_q == RUN) begin
          if (!enable_i) state_d = DRAIN;
        end else if (enable_i) begin
          state_d = RUN;
        end else if (h_last && v_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk_hdmi_i or negedge rst_hdmi_ni) begin
    if (!rst_hdmi_ni) begin
      state_q   <= IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      running_q <= 1'b0;
      req_q     <= 1'b0;
      fs_q      <= 1'b0;
      hs_act_q  <= 1'b0;
      vs_act_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      de_q      <= 1'b0;
      hs_q      <= ~HSyncPol;
      vs_q      <= ~VSyncPol;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      running_q <= (state_d != IDLE);
      // Stage 1: request and coordinates; coordinates hold outside active video.
      req_q     <= active_s0;
      fs_q      <= fs_s0;
      hs_act_q  <= hs_act_s0;
      vs_act_q  <= vs_act_s0;
      if (active_s0) begin
        x_q <= h_cnt_q[XW-1:0];
        y_q <= v_cnt_q[YW-1:0];
      end
      // Stage 2: syncs delayed to line up with the pixel data returned one cycle later.
      de_q      <= req_q;
      hs_q      <= hs_act_q ? HSyncPol : ~HSyncPol;
      vs_q      <= vs_act_q ? VSyncPol : ~VSyncPol;
      r_q       <= req_q ? pix_r_i : 8'h00;
      g_q       <= req_q ? pix_g_i : 8'h00;
      b_q       <= req_q ? pix_b_i : 8'h00;
    end
  end

  assign pix_req_o     = req_q;
  assign pix_x_o       = x_q;
  assign pix_y_o       = y_q;
  assign frame_start_o = fs_q;
  assign running_o     = running_q;
  assign hdmi_tx_de_o  = de_q;
  assign hdmi_tx_hs_o  = hs_q;
  assign hdmi_tx_vs_o  = vs_q;
  assign hdmi_tx_r_o   = r_q;
  assign hdmi_tx_g_o   = g_q;
  assign hdmi_tx_b_o   = b_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: a wide-line/short-frame instance and a tiny instance,
// both compared every cycle against a frame-position reference model.
module tb_hdmi_timing_gen;

  localparam int HA [2] = '{640, 4};
  localparam int HF [2] = '{16, 1};
  localparam int HSW[2] = '{96, 2};
  localparam int HB [2] = '{48, 1};
  localparam int VA [2] = '{6, 2};
  localparam int VF [2] = '{1, 1};
  localparam int VSW[2] = '{2, 1};
  localparam int VB [2] = '{2, 1};
  localparam bit HP [2] = '{1'b0, 1'b1};
  localparam bit VP [2] = '{1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic       a_req, a_fs, a_run, a_de, a_hs, a_vs;
  logic [9:0] a_x;
  logic [2:0] a_y;
  logic [7:0] a_r, a_g, a_b, a_pr, a_pg, a_pb;
  logic       b_req, b_fs, b_run, b_de, b_hs, b_vs;
  logic [1:0] b_x;
  logic [0:0] b_y;
  logic [7:0] b_r, b_g, b_b, b_pr, b_pg, b_pb;

  initial begin
    {a_pr, a_pg, a_pb} = '0;
    {b_pr, b_pg, b_pb} = '0;
  end

  hdmi_timing_gen #(
    .HActive(HA[0]), .HFront(HF[0]), .HSync(HSW[0]), .HBack(HB[0]),
    .VActive(VA[0]), .VFront(VF[0]), .VSync(VSW[0]), .VBack(VB[0]),
    .HSyncPol(HP[0]), .VSyncPol(VP[0])
  ) u_a (
    .clk_hdmi_i(clk), .rst_hdmi_ni(rst_n), .enable_i(en),
    .pix_req_o(a_req), .pix_x_o(a_x), .pix_y_o(a_y),
    .pix_r_i(a_pr), .pix_g_i(a_pg), .pix_b_i(a_pb),
    .frame_start_o(a_fs), .running_o(a_run),
    .hdmi_tx_de_o(a_de), .hdmi_tx_hs_o(a_hs), .hdmi_tx_vs_o(a_vs),
    .hdmi_tx_r_o(a_r), .hdmi_tx_g_o(a_g), .hdmi_tx_b_o(a_b)
  );

  hdmi_timing_gen #(
    .HActive(HA[1]), .HFront(HF[1]), .HSync(HSW[1]), .HBack(HB[1]),
    .VActive(VA[1]), .VFront(VF[1]), .VSync(VSW[1]), .VBack(VB[1]),
    .HSyncPol(HP[1]), .VSyncPol(VP[1])
  ) u_b (
    .clk_hdmi_i(clk), .rst_hdmi_ni(rst_n), .enable_i(en),
    .pix_req_o(b_req), .pix_x_o(b_x), .pix_y_o(b_y),
    .pix_r_i(b_pr), .pix_g_i(b_pg), .pix_b_i(b_pb),
    .frame_start_o(b_fs), .running_o(b_run),
    .hdmi_tx_de_o(b_de), .hdmi_tx_hs_o(b_hs), .hdmi_tx_vs_o(b_vs),
    .hdmi_tx_r_o(b_r), .hdmi_tx_g_o(b_g), .hdmi_tx_b_o(b_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a linear position t within the frame plus on/draining flags.
  typedef struct {
    bit          on;
    bit          drain;
    int          t;
    bit          s1_req, s1_fs, s1_hs, s1_vs;
    int          s1_x, s1_y;
    bit          s2_de, s2_hs, s2_vs;
    logic [23:0] s2_rgb;
  } model_t;

  model_t m[2];

  function automatic int htot(int i);
    return HA[i] + HF[i] + HSW[i] + HB[i];
  endfunction

  function automatic int vtot(int i);
    return VA[i] + VF[i] + VSW[i] + VB[i];
  endfunction

  function automatic model_t model_reset();
    model_t n;
    n = '{default: 0};
    n.s2_rgb = 24'h0;
    return n;
  endfunction

  function automatic model_t model_step(model_t s, int i, bit en_i, logic [23:0] pix);
    model_t n = s;
    int total = htot(i) * vtot(i);
    int h = s.t % htot(i);
    int v = s.t / htot(i);
    n.s2_de  = s.s1_req;
    n.s2_hs  = s.s1_hs;
    n.s2_vs  = s.s1_vs;
    n.s2_rgb = s.s1_req ? pix : 24'h0;
    n.s1_req = s.on && h < HA[i] && v < VA[i];
    if (n.s1_req) begin
      n.s1_x = h;
      n.s1_y = v;
    end
    n.s1_fs = s.on && s.t == 0;
    n.s1_hs = s.on && h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HSW[i];
    n.s1_vs = s.on && v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VSW[i];
    if (!s.on) begin
      if (en_i) begin
        n.on = 1'b1;
        n.drain = 1'b0;
        n.t = 0;
      end
    end else begin
      if (s.drain && en_i) n.drain = 1'b0;
      else if (s.drain && s.t == total - 1) n.on = 1'b0;
      else if (!s.drain && !en_i) n.drain = 1'b1;
      n.t = n.on ? (s.t + 1) % total : 0;
    end
    return n;
  endfunction

  function automatic logic [61:0] model_out(model_t s, int i);
    return {s.s1_req, s.s1_fs, s.on, s.s2_de,
            s.s2_hs ? HP[i] : ~HP[i], s.s2_vs ? VP[i] : ~VP[i],
            16'(s.s1_x), 16'(s.s1_y), s.s2_rgb};
  endfunction

  logic [61:0] act_a, act_b;
  assign act_a = {a_req, a_fs, a_run, a_de, a_hs, a_vs, 16'(a_x), 16'(a_y), a_r, a_g, a_b};
  assign act_b = {b_req, b_fs, b_run, b_de, b_hs, b_vs, 16'(b_x), 16'(b_y), b_r, b_g, b_b};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= model_reset();
      m[1] <= model_reset();
    end else begin
      m[0] <= model_step(m[0], 0, en, {a_pr, a_pg, a_pb});
      m[1] <= model_step(m[1], 1, en, {b_pr, b_pg, b_pb});
    end
  end

  // Compare every cycle, then act as the pixel source for the next edge:
  // r = x, g = y, b = A5 for requested pixels, noise otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model A", act_a, model_out(m[0], 0));
      check("model B", act_b, model_out(m[1], 1));
    end
    if (m[0].s1_req) {a_pr, a_pg, a_pb} = {8'(m[0].s1_x), 8'(m[0].s1_y), 8'hA5};
    else             {a_pr, a_pg, a_pb} = 24'($urandom);
    if (m[1].s1_req) {b_pr, b_pg, b_pb} = {8'(m[1].s1_x), 8'(m[1].s1_y), 8'hA5};
    else             {b_pr, b_pg, b_pb} = 24'($urandom);
  end

  // Hand-derived output levels, n = negedges after the edge that enters RUN.
  typedef struct {
    int inst;
    int cyc;
    bit de, hs, vs, fs;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];

  localparam logic [61:0] RST_A = {6'b000011, 16'd0, 16'd0, 24'd0};
  localparam logic [61:0] RST_B = {6'b000001, 16'd0, 16'd0, 24'd0};

  initial begin
    int cnt;
    bit done;

    tbl[0]  = '{1, 1,   0, 0, 1, 1};
    tbl[1]  = '{1, 2,   1, 0, 1, 0};
    tbl[2]  = '{1, 5,   1, 0, 1, 0};
    tbl[3]  = '{1, 6,   0, 0, 1, 0};
    tbl[4]  = '{1, 7,   0, 1, 1, 0};
    tbl[5]  = '{1, 8,   0, 1, 1, 0};
    tbl[6]  = '{1, 9,   0, 0, 1, 0};
    tbl[7]  = '{1, 10,  1, 0, 1, 0};
    tbl[8]  = '{1, 26,  0, 0, 0, 0};
    tbl[9]  = '{1, 33,  0, 0, 0, 0};
    tbl[10] = '{1, 34,  0, 0, 1, 0};
    tbl[11] = '{1, 41,  0, 0, 1, 1};
    tbl[12] = '{1, 42,  1, 0, 1, 0};
    tbl[13] = '{0, 1,   0, 1, 1, 1};
    tbl[14] = '{0, 2,   1, 1, 1, 0};
    tbl[15] = '{0, 641, 1, 1, 1, 0};
    tbl[16] = '{0, 642, 0, 1, 1, 0};
    tbl[17] = '{0, 657, 0, 1, 1, 0};
    tbl[18] = '{0, 658, 0, 0, 1, 0};
    tbl[19] = '{0, 753, 0, 0, 1, 0};
    tbl[20] = '{0, 754, 0, 1, 1, 0};
    tbl[21] = '{0, 802, 1, 1, 1, 0};

    repeat (3) @(negedge clk);
    check("reset A", act_a, RST_A);
    check("reset B", act_b, RST_B);
    #2 rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;

    for (int n = 0; n <= 802; n++) begin
      @(negedge clk);
      for (int k = 0; k < NV; k++) begin
        if (tbl[k].cyc == n) begin
          if (tbl[k].inst == 0)
            check("table A", {a_de, a_hs, a_vs, a_fs}, {tbl[k].de, tbl[k].hs, tbl[k].vs, tbl[k].fs});
          else
            check("table B", {b_de, b_hs, b_vs, b_fs}, {tbl[k].de, tbl[k].hs, tbl[k].vs, tbl[k].fs});
        end
      end
    end

    // Drop enable mid-frame at pixel (100,3): the frame must still complete in full.
    done = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (a_fs) begin
        done = 1'b1;
        break;
      end
    end
    check("wait frame start", 64'(done), 64'd1);
    cnt = 0;
    done = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (a_req) cnt++;
      if (m[0].s1_req && m[0].s1_x == 100 && m[0].s1_y == 3) en = 1'b0;
      if (!a_run) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("drain reaches idle", 64'(done), 64'd1);
    check("requests in drained frame", 64'(cnt), 64'(HA[0] * VA[0]));
    repeat (5) @(negedge clk);
    check("idle A", {a_run, a_req, a_de, a_hs, a_vs}, 5'b00011);
    check("idle B", {b_run, b_req, b_de, b_hs, b_vs}, 5'b00001);

    // Random enable bursts, checked against the model every cycle.
    for (int s = 0; s < 10; s++) begin
      en = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(10, 2500)) @(negedge clk);
    end

    // Asynchronous reset in the middle of line, at h = 300.
    en = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (m[0].on && (m[0].t % htot(0)) == 300) begin
        done = 1'b1;
        break;
      end
    end
    check("wait h=300", 64'(done), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset A", act_a, RST_A);
    check("async reset B", act_b, RST_B);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("restart A first pixel", {a_fs, a_req, a_x, a_y}, {2'b11, 10'd0, 3'd0});
    check("restart B first pixel", {b_fs, b_req, b_x, b_y}, {2'b11, 2'd0, 1'd0});
    repeat (300) @(negedge clk);
    en = 1'b0;
    repeat (100) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
